dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 8 +
 rtl/mmio_regs.sv | 34 +++
 rtl/dmem_ctrl.sv | 92 +++++++++
 tb/tb_dmem_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, MMIO register offsets and default MMIO window base
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, RAM_RD, RESP} state_e;
  localparam logic [11:0] OFF_LED = 12'h000;
  localparam logic [11:0] OFF_SW = 12'h004;
  localparam logic [11:0] OFF_CYCLE = 12'h008;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;
endpackage

// File: rtl/mmio_regs.sv
// mmio_regs: LED register, 2-flop switch synchronizer and free-running cycle counter
// Ports: clk, rst (async active-low); led_we_i/led_be_i/led_wdata_i write the LED
//        byte lanes; sw_i raw switches; led_o, sw_o (synchronized), cycle_o.
module mmio_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_we_i,
  input  logic [1:0]  led_be_i,
  input  logic [15:0] led_wdata_i,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic [15:0] sw_o,
  output logic [31:0] cycle_o
);
  logic [15:0] led_q, led_d, sw_meta_q, sw_sync_q;
  logic [31:0] cyc_q;
  always_comb led_d = {led_we_i && led_be_i[1] ? led_wdata_i[15:8] : led_q[15:8],
                       led_we_i && led_be_i[0] ? led_wdata_i[7:0] : led_q[7:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      led_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cyc_q <= '0;
    end else begin
      led_q <= led_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
      cyc_q <= cyc_q + 32'd1;
    end
  assign led_o = led_q;
  assign sw_o = sw_sync_q;
  assign cycle_o = cyc_q;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU data-memory controller decoding requests to RAM, MMIO or error
// Ports: clk, rst (async active-low); req_* request channel (ready only when idle);
//        rsp_* one-cycle response pulse; ram_* synchronous RAM port (1-cycle read);
//        led_out / sw_in board pins served through the MMIO window.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [3:0]                   req_be,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic                         ram_en,
  output logic [3:0]                   ram_we,
  output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata,
  output logic [15:0]                  led_out,
  input  logic [15:0]                  sw_in
);
  localparam int AW = $clog2(RAM_WORDS);
  state_e state_q;
  logic rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q, cycle, mmio_rdata;
  logic [15:0] sw_sync;
  logic [11:0] off;
  logic ram_hit, mmio_hit, reg_hit, err, accept, ram_acc, led_we;
  always_comb begin
    off = req_addr[11:0];
    ram_hit = req_addr < 32'(4 * RAM_WORDS);
    mmio_hit = req_addr[31:12] == MMIO_BASE[31:12];
    reg_hit = mmio_hit && (off == OFF_LED || off == OFF_SW || off == OFF_CYCLE);
    err = req_addr[1:0] != 2'b00 || !(ram_hit || reg_hit);
    // gating with rst keeps the RAM strobes quiet while reset is held
    accept = rst && req_valid && state_q == IDLE;
    ram_acc = accept && ram_hit && !err;
    led_we = accept && reg_hit && !err && req_we && off == OFF_LED;
    mmio_rdata = off == OFF_LED ? {16'h0, led_out} : off == OFF_SW ? {16'h0, sw_sync} : cycle;
  end
  mmio_regs u_mmio (
    .clk         (clk),
    .rst         (rst),
    .led_we_i    (led_we),
    .led_be_i    (req_be[1:0]),
    .led_wdata_i (req_wdata[15:0]),
    .sw_i        (sw_in),
    .led_o       (led_out),
    .sw_o        (sw_sync),
    .cycle_o     (cycle)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          // RAM reads wait one cycle for the RAM; everything else answers next cycle
          state_q <= ram_acc && !req_we ? RAM_RD : RESP;
          rsp_valid_q <= !(ram_acc && !req_we);
          rsp_rdata_q <= reg_hit && !err && !req_we ? mmio_rdata : 32'h0;
          rsp_err_q <= err;
        end
        RAM_RD: begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ram_rdata;
        end
        default: begin
          state_q <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  assign req_ready = state_q == IDLE;
  assign ram_en = ram_acc;
  assign ram_we = ram_acc && req_we ? req_be : 4'h0;
  assign ram_addr = req_addr[AW+1:2];
  assign ram_wdata = req_wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl with a behavioural 1-cycle RAM
module tb_dmem_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [3:0] req_be = 4'h0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rsp_valid, rsp_err, ram_en;
  logic [31:0] rsp_rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_we;
  logic [9:0] ram_addr;
  logic [15:0] led_out, sw_in = 16'h0;
  typedef struct {
    string tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic err;
    int acc;
    int lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, tb_cyc = 0, ram_en_cnt = 0;
  logic [31:0] mem [0:1023];
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .led_out(led_out), .sw_in(sw_in)
  );
  always @(posedge clk) begin
    tb_cyc <= tb_cyc + 1;
    if (ram_en) begin
      ram_en_cnt <= ram_en_cnt + 1;
      ram_rdata <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i+:8] <= ram_wdata[8*i+:8];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        checks++;
        assert (rsp_rdata >= e.lo && rsp_rdata <= e.hi) else begin
          errors++;
          $error("FAIL %s_rdata: got %h expected %h..%h", e.tag, rsp_rdata, e.lo, e.hi);
        end
        chk({e.tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
        chk({e.tag, "_lat"}, 32'(tb_cyc - e.acc), 32'(e.lat));
      end
    end
  end
  task automatic req(input string tag, input logic we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] lo,
                     input logic [31:0] hi, input logic e, input int lat);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = a; req_wdata = wd;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
    sb.push_back('{tag, lo, hi, e, tb_cyc, lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input logic e);
    req(tag, 1'b1, be, a, wd, 32'h0, 32'h0, e, 1);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                    input logic e, input int lat);
    req(tag, 1'b0, 4'hF, a, 32'h0, exp, exp, e, lat);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    int base;
    req_valid = 1'b1; req_addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_led", {16'h0, led_out}, 32'd0);
    chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
    chk("rst_ram_we", {28'h0, ram_we}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
    wr("ram_wr", 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    rd("ram_rd", 32'h10, 32'hDEADBEEF, 1'b0, 2);
    wr("ram_wr14", 32'h14, 4'hF, 32'hAAAAAAAA, 1'b0);
    wr("ram_wr14_be", 32'h14, 4'b0101, 32'h11223344, 1'b0);
    rd("ram_rd14", 32'h14, 32'hAA22AA44, 1'b0, 2);
    wr("ram_wr_top", 32'hFFC, 4'hF, 32'h12345678, 1'b0);
    rd("ram_rd_top", 32'hFFC, 32'h12345678, 1'b0, 2);
    wr("led_wr", 32'hF000_0000, 4'b0011, 32'h0000_1234, 1'b0);
    chk("led_1234", {16'h0, led_out}, 32'h1234);
    wr("led_wr_b1", 32'hF000_0000, 4'b0010, 32'h0000_AB00, 1'b0);
    chk("led_ab34", {16'h0, led_out}, 32'hAB34);
    rd("led_rd", 32'hF000_0000, 32'h0000_AB34, 1'b0, 1);
    sw_in = 16'h5A5A;
    rd("sw_rd_old", 32'hF000_0004, 32'h0, 1'b0, 1);
    rd("sw_rd_new", 32'hF000_0004, 32'h5A5A, 1'b0, 1);
    wr("sw_wr", 32'hF000_0004, 4'hF, 32'hFFFF_FFFF, 1'b0);
    rd("sw_rd_after_wr", 32'hF000_0004, 32'h5A5A, 1'b0, 1);
    drain();
    base = ram_en_cnt;
    rd("mis_rd", 32'h0000_0002, 32'h0, 1'b1, 1);
    rd("unmap_rd", 32'h8000_0000, 32'h0, 1'b1, 1);
    rd("past_ram_rd", 32'h0000_1000, 32'h0, 1'b1, 1);
    rd("mmio_c_rd", 32'hF000_000C, 32'h0, 1'b1, 1);
    rd("mmio_out_rd", 32'hF000_1000, 32'h0, 1'b1, 1);
    wr("mis_wr", 32'h0000_0012, 4'hF, 32'h5555_5555, 1'b1);
    drain();
    chk("err_no_ram_en", 32'(ram_en_cnt - base), 32'd0);
    rd("ram_rd14_intact", 32'h10, 32'hDEADBEEF, 1'b0, 2);
    drain();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (100) @(posedge clk);
    req("cyc_rd", 1'b0, 4'hF, 32'hF000_0008, 32'h0, 32'd100, 32'd103, 1'b0, 1);
    wr("cyc_wr", 32'hF000_0008, 4'hF, 32'h0, 1'b0);
    drain();
    @(negedge clk); force dut.u_mmio.cyc_q = 32'hFFFF_FFFE;
    @(negedge clk); release dut.u_mmio.cyc_q;
    rd("cyc_max_rd", 32'hF000_0008, 32'hFFFF_FFFF, 1'b0, 1);
    chk("cyc_wrap", dut.u_mmio.cyc_q, 32'h0);
    rd("cyc_after_wrap", 32'hF000_0008, 32'h1, 1'b0, 1);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rd_ready_low", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk); rst = 1'b1;
    chk("mid_release_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h10;
    chk("b2b_ready_idle", {31'b0, req_ready}, 32'd1);
    sb.push_back('{"b2b_first", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, tb_cyc, 2});
    @(negedge clk);
    chk("b2b_ready_ramrd", {31'b0, req_ready}, 32'd0);
    chk("b2b_ram_en_ramrd", {31'b0, ram_en}, 32'd0);
    req_addr = 32'h14;
    @(negedge clk);
    chk("b2b_ready_resp", {31'b0, req_ready}, 32'd0);
    chk("b2b_ram_en_resp", {31'b0, ram_en}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_again", {31'b0, req_ready}, 32'd1);
    sb.push_back('{"b2b_second", 32'hAA22AA44, 32'hAA22AA44, 1'b0, tb_cyc, 2});
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
